// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants, fetch buffer entry type and address helper for the fetch stage
package if_fetch_pkg;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [INST_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_WIDTH-1:0] word_align(input logic [INST_ADDR_WIDTH-1:0] a);
        return {a[INST_ADDR_WIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous {pc,inst} buffer with flush; head is read straight from storage registers
module if_fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t push_data_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    // pointer and occupancy update; clear wins over a same-cycle push or pop
    always_comb begin
        rd_d    = clear_i ? '0 : rd_q + AW'(pop_i);
        wr_d    = clear_i ? '0 : wr_q + AW'(push_i);
        count_d = clear_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // storage write; when full the slot written is the one being popped this cycle
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC/issue logic with credit-limited in-flight fetches, response tracking and redirect flush
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                       imem_req_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
    output logic                       inst_valid_o,
    output logic [DATA_WIDTH-1:0]      inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc_o,
    input  logic                       inst_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
    logic fire, rv, keep, pop;
    fetch_entry_t head;

    assign target       = word_align(redirect_pc_i);
    assign imem_req_o   = !rst && !redirect_i && (({1'b0, out_q} + {1'b0, count}) < CAP);
    assign imem_addr_o  = pc_q;
    assign fire         = imem_req_o && imem_gnt_i;
    assign rv           = imem_rvalid_i && (out_q != '0);
    assign keep         = rv && (disc_q == '0) && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
    assign inst_valid_o = count != '0;
    assign inst_o       = inst_valid_o ? head.inst : ZERO;
    assign inst_pc_o    = inst_valid_o ? head.pc : ZERO;

    // next PC, response PC and counters; a redirect turns every still-pending fetch into a discard
    always_comb begin
        pc_d     = redirect_i ? target : fire ? pc_q + 32'd4 : pc_q;
        rsp_pc_d = redirect_i ? target : keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        out_d    = out_q + CW'(fire) - CW'(rv);
        disc_d   = redirect_i ? out_q - CW'(rv) : disc_q - CW'(rv && disc_q != '0);
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
        end
    end

    if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (keep),
        .pop_i      (pop),
        .clear_i    (redirect_i),
        .push_data_i('{pc: rsp_pc_q, inst: imem_rdata_i}),
        .count_o    (count),
        .head_o     (head)
    );

    rvalid_without_request: assert property (@(posedge clk) disable iff (rst) !(imem_rvalid_i && out_q == '0));
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table, hand-written corner sequences and a randomized run against a queue model
module tb_if_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] A = 32'h8000_0000;

    logic clk = 0, rst = 1, redirect = 0, gnt = 0, rvalid = 0, ready = 0;
    logic [31:0] redirect_pc = 0, rdata = 0;
    logic req, valid;
    logic [31:0] addr, inst, inst_pc;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(A), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(inst_pc),
        .inst_ready_i(ready)
    );

    typedef struct {
        logic rd; logic [31:0] rpc; logic g, v; logic [31:0] dpc; logic rdy;
        logic req; logic [31:0] addr; logic val; logic [31:0] pc;
    } vec_t;
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] pc, inst; } be_t;

    vec_t vt [19];
    fl_t m_fl [$];
    be_t m_buf [$];
    logic [31:0] mq [$];
    logic [31:0] m_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'h00C3};
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic g, v,
                                input logic [31:0] dpc, input logic rdy, input logic rq,
                                input logic [31:0] ad, input logic vl, input logic [31:0] pc);
        return '{rd: rd, rpc: rpc, g: g, v: v, dpc: dpc, rdy: rdy, req: rq, addr: ad, val: vl, pc: pc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic r, rd, input logic [31:0] rpc, input logic g, v,
                       input logic [31:0] d, input logic rdy);
        rst = r; redirect = rd; redirect_pc = rpc; gnt = g; rvalid = v; rdata = d; ready = rdy;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0, 0);
        nxt();
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_addr", addr, A);
        nxt();
        rst = 0;
    endtask

    task automatic chk_out(input string nm, input logic vl, input logic [31:0] pc);
        chk({nm, "_valid"}, valid, vl);
        chk({nm, "_pc"}, inst_pc, vl ? pc : 0);
        chk({nm, "_inst"}, inst, vl ? data_of(pc) : 0);
    endtask

    initial begin
        vt[0]  = mk(0, 0,       1, 0, 0,      1, 1, A,       0, 0);
        vt[1]  = mk(0, 0,       1, 1, A,      1, 1, A+4,     0, 0);
        vt[2]  = mk(0, 0,       1, 1, A+4,    1, 0, A+8,     1, A);
        vt[3]  = mk(0, 0,       1, 0, 0,      1, 1, A+8,     1, A+4);
        vt[4]  = mk(0, 0,       1, 1, A+8,    1, 1, A+'hC,   0, 0);
        vt[5]  = mk(0, 0,       1, 1, A+'hC,  1, 0, A+'h10,  1, A+8);
        vt[6]  = mk(0, 0,       0, 0, 0,      1, 1, A+'h10,  1, A+'hC);
        vt[7]  = mk(0, 0,       0, 0, 0,      1, 1, A+'h10,  0, 0);
        vt[8]  = mk(0, 0,       0, 0, 0,      1, 1, A+'h10,  0, 0);
        vt[9]  = mk(0, 0,       1, 0, 0,      1, 1, A+'h10,  0, 0);
        vt[10] = mk(0, 0,       1, 1, A+'h10, 1, 1, A+'h14,  0, 0);
        vt[11] = mk(0, 0,       1, 0, 0,      1, 0, A+'h18,  1, A+'h10);
        vt[12] = mk(0, 0,       1, 0, 0,      1, 1, A+'h18,  0, 0);
        vt[13] = mk(1, A+'h102, 1, 0, 0,      1, 0, A+'h1C,  0, 0);
        vt[14] = mk(0, 0,       1, 1, A+'h14, 1, 0, A+'h100, 0, 0);
        vt[15] = mk(0, 0,       1, 1, A+'h18, 1, 1, A+'h100, 0, 0);
        vt[16] = mk(0, 0,       1, 1, A+'h100,1, 1, A+'h104, 0, 0);
        vt[17] = mk(0, 0,       1, 1, A+'h104,1, 0, A+'h108, 1, A+'h100);
        vt[18] = mk(0, 0,       1, 0, 0,      1, 1, A+'h108, 1, A+'h104);

        #1;
        do_reset();
        foreach (vt[i]) begin
            drv(0, vt[i].rd, vt[i].rpc, vt[i].g, vt[i].v, data_of(vt[i].dpc), vt[i].rdy);
            chk($sformatf("vec%0d_req", i), req, vt[i].req);
            chk($sformatf("vec%0d_addr", i), addr, vt[i].addr);
            chk_out($sformatf("vec%0d", i), vt[i].val, vt[i].pc);
            nxt();
        end

        do_reset();
        drv(0, 0, 0, 1, 0, 0, 0);         nxt();
        drv(0, 0, 0, 1, 1, data_of(A), 0); nxt();
        drv(0, 0, 0, 1, 1, data_of(A+4), 0);
        chk("fill_req_off", req, 0);        nxt();
        drv(0, 0, 0, 1, 0, 0, 1);
        chk("full_req_off", req, 0);
        chk_out("full_head", 1, A);         nxt();
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("after_pop_req", req, 1);
        chk("after_pop_addr", addr, A+8);
        chk_out("after_pop_head", 1, A+4);  nxt();
        drv(0, 0, 0, 1, 1, data_of(A+8), 0);
        chk("refill_req_off", req, 0);      nxt();

        do_reset();
        drv(0, 0, 0, 1, 0, 0, 0);         nxt();
        drv(0, 0, 0, 1, 1, data_of(A), 0); nxt();
        drv(0, 1, A+'h200, 1, 1, data_of(A+4), 1);
        chk("redir_req", req, 0);
        chk_out("redir_head", 1, A);        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk_out("flushed", 0, 0);
        chk("redir_addr", addr, A+'h200);   nxt();
        drv(0, 0, 0, 1, 0, 0, 0);         nxt();
        drv(0, 0, 0, 0, 1, data_of(A+'h200), 0);
        chk_out("redir_wait", 0, 0);        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk_out("redir_first", 1, A+'h200); nxt();

        do_reset();
        drv(0, 0, 0, 1, 0, 0, 0);         nxt();
        drv(0, 0, 0, 1, 0, 0, 0);         nxt();
        drv(0, 1, A+'h300, 1, 1, data_of(A), 1); nxt();
        drv(0, 0, 0, 1, 1, data_of(A+4), 0);
        chk("disc_addr", addr, A+'h300);    nxt();
        drv(0, 0, 0, 0, 1, data_of(A+'h300), 0);
        chk_out("disc_dropped", 0, 0);
        chk("disc_next_addr", addr, A+'h304); nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk_out("disc_kept", 1, A+'h300);   nxt();

        do_reset();
        drv(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("wrap_redir_req", req, 0);      nxt();
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("wrap_addr0", addr, 32'hFFFF_FFFC); nxt();
        drv(0, 0, 0, 1, 1, data_of(32'hFFFF_FFFC), 0);
        chk("wrap_addr1", addr, 32'h0000_0000); nxt();
        drv(0, 0, 0, 1, 1, data_of(32'h0), 0);
        chk_out("wrap_head", 1, 32'hFFFF_FFFC); nxt();
        drv(1, 0, 0, 1, 0, 0, 1);
        chk("midrst_req", req, 0);          nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_addr", addr, A);
        chk_out("midrst_out", 0, 0);        nxt();

        do_reset();
        m_pc = A;
        for (int c = 0; c < 3000; c++) begin
            logic r, rd, g, v, rdy, ereq, dfire;
            logic [31:0] rpc, d, daddr;
            fl_t f;
            r   = ($urandom % 300) == 0;
            rd  = ($urandom % 12) == 0;
            rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            g   = ($urandom % 3) != 0;
            v   = (mq.size() > 0) && ($urandom % 2 == 1);
            d   = v ? data_of(mq[0]) : $urandom;
            rdy = ($urandom % 4) != 0;
            drv(r, rd, rpc, g, v, d, rdy);
            ereq = !r && !rd && (m_fl.size() + m_buf.size() < DEPTH);
            chk("rnd_req", req, ereq);
            chk("rnd_addr", addr, m_pc);
            chk("rnd_valid", valid, m_buf.size() > 0);
            chk("rnd_inst", inst, m_buf.size() > 0 ? m_buf[0].inst : 0);
            chk("rnd_pc", inst_pc, m_buf.size() > 0 ? m_buf[0].pc : 0);
            dfire = req && g;
            daddr = addr;
            nxt();
            if (r) begin
                m_pc = A;
                m_fl.delete();
                m_buf.delete();
                mq.delete();
            end else begin
                f = '{pc: 0, stale: 1};
                if (v) begin
                    void'(mq.pop_front());
                    if (m_fl.size() > 0) f = m_fl.pop_front();
                end
                if (dfire) mq.push_back(daddr);
                if (rd) begin
                    m_buf.delete();
                    foreach (m_fl[k]) m_fl[k].stale = 1;
                    m_pc = {rpc[31:2], 2'b00};
                end else begin
                    if (m_buf.size() > 0 && rdy) void'(m_buf.pop_front());
                    if (v && !f.stale) m_buf.push_back('{pc: f.pc, inst: d});
                    if (ereq && g) begin
                        m_fl.push_back('{pc: m_pc, stale: 0});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
